// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package arb_pkg;

    // Upper bound on requester count supported by the helper functions.
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Rotate the low w bits of v right by one; bits at and above w must be zero.
    function automatic logic [MAX_WIDTH-1:0] ror1(input logic [MAX_WIDTH-1:0] v,
                                                  input int unsigned          w);
        logic [MAX_WIDTH-1:0] r;
        r = v >> 1;
        r[MAX_IDX_W'(w - 1)] = v[0];
        return r;
    endfunction

    // Binary index of the set bit among the low w bits; 0 for an all-zero vector.
    function automatic int unsigned onehot2bin(input logic [MAX_WIDTH-1:0] v,
                                               input int unsigned          w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < w && v[MAX_IDX_W'(i)]) begin
                r = r | i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: highest-priority requester, descending from ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned width = 4
) (
    input  logic [width-1:0] req,
    input  logic [width-1:0] ptr,
    output logic [width-1:0] win,
    output logic             any
);

    localparam int unsigned IdW = $clog2(width);

    int unsigned top;
    int unsigned idx;
    logic        found;

    // Walk ptr, ptr-1, ..., wrapping to width-1, and take the first requester.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        top   = onehot2bin(MAX_WIDTH'(ptr), width);
        for (int unsigned i = 0; i < width; i++) begin
            idx = (top + width - i) % width;
            if (!found && req[IdW'(idx)]) begin
                win[IdW'(idx)] = 1'b1;
                found          = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin ring arbiter with registered one-hot grant and optional hold timeout.
module rr_ring_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned width    = 4,
    parameter int unsigned max_hold = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width-1:0]         req,
    output logic [width-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(width)-1:0] grant_id,
    output logic                     timeout
);

    localparam int unsigned IdW  = $clog2(width);
    localparam int unsigned CntW = (max_hold == 0) ? 1 : $clog2(max_hold + 1);

    state_e           state_q, state_d;
    logic [width-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [width-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IdW-1:0]   id_q, id_d;
    logic             timeout_q, timeout_d;

    logic [width-1:0]     win;
    logic                 any;
    logic [MAX_WIDTH-1:0] rot;
    logic                 unused_rot;
    logic                 still_req;
    logic                 hold_expired;

    rr_pick #(
        .width(width)
    ) u_pick (
        .req(req),
        .ptr(ptr_q),
        .win(win),
        .any(any)
    );

    // Pointer candidate: the current winner's right neighbour.
    assign rot          = ror1(MAX_WIDTH'(grant_q), width);
    assign unused_rot   = ^rot;
    assign still_req    = |(req & grant_q);
    assign hold_expired = (max_hold != 0) && (cnt_q == CntW'(max_hold - 1));

    // Next-state logic; release takes precedence over timeout on the same edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = win;
                    cnt_d   = '0;
                    state_d = GRANT;
                end else begin
                    grant_d = '0;
                end
            end
            GRANT: begin
                if (!still_req) begin
                    grant_d = '0;
                    ptr_d   = rot[width-1:0];
                    state_d = IDLE;
                end else if (hold_expired) begin
                    grant_d   = '0;
                    ptr_d     = rot[width-1:0];
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = |grant_d;
        id_d    = IdW'(onehot2bin(MAX_WIDTH'(grant_d), width));
    end

    // State and output registers; reset returns the pointer to MSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= {1'b1, {(width - 1){1'b0}}};
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Scoreboard bench for rr_ring_arbiter: directed scenarios plus random traffic.
module tb_rr_ring_arbiter;

    localparam int W = 4;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic [W-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         timeout;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner index (-1 idle), cycles owned, top-priority index.
    int owner = -1;
    int held  = 0;
    int top   = W - 1;

    int want[W];
    int budget[W];

    rr_ring_arbiter #(
        .width(W),
        .max_hold(M)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic bit has_bit(input logic [3:0] r, input int i);
        return ((r >> i) & 4'b0001) != 4'b0000;
    endfunction

    task automatic model_reset();
        owner = -1;
        held  = 0;
        top   = W - 1;
    endtask

    // Outcome of one clock edge given the request vector present before it.
    function automatic exp_t model_step(input logic [3:0] r);
        exp_t e;
        bit   tout;
        bit   found;
        int   i;
        tout  = 1'b0;
        found = 1'b0;
        if (owner < 0) begin
            for (int k = 0; k < W; k++) begin
                i = (top - k + W) % W;
                if (!found && has_bit(r, i)) begin
                    owner = i;
                    held  = 1;
                    found = 1'b1;
                end
            end
        end else if (!has_bit(r, owner)) begin
            top   = (owner + W - 1) % W;
            owner = -1;
        end else if (held == M) begin
            top   = (owner + W - 1) % W;
            owner = -1;
            tout  = 1'b1;
        end else begin
            held++;
        end
        e.g  = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        e.id = (owner >= 0) ? 2'(owner) : 2'd0;
        e.v  = (owner >= 0);
        e.to = tout;
        return e;
    endfunction

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        exp_q.push_back(model_step(r));
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({grant, grant_id, grant_valid, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL %s: grant=%b id=%0d valid=%b timeout=%b, expected all zero",
                     name, grant, grant_id, grant_valid, timeout);
        end
    endtask

    // Monitor: compare each registered output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({grant, grant_id, grant_valid, timeout} !== e) begin
                    errors++;
                    $display("FAIL grant_out @%0t: grant=%b id=%0d valid=%b timeout=%b, expected grant=%b id=%0d valid=%b timeout=%b",
                             $time, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.to);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        int         waited;

        rst = 1'b1;
        req = '0;
        #1;
        check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single request and rotation fairness.
        step(4'b0101);
        step(4'b0001);
        step(4'b0101);
        step(4'b0100);
        step(4'b0101);
        step(4'b0000);
        step(4'b0000);

        // All requesting; each winner drops after two cycles.
        for (int n = 0; n < 16; n++) begin
            r = 4'b1111;
            if (owner >= 0 && held == 2) r = r & ~(4'b0001 << owner);
            step(r);
        end
        step(4'b0000);
        step(4'b0000);

        // Continuous hold hits the timeout, then with a competitor.
        repeat (20) step(4'b0010);
        step(4'b0000);
        step(4'b0000);
        repeat (20) step(4'b0011);
        step(4'b0000);
        step(4'b0000);

        // Random traffic: requests stay high until their owned-cycle budget runs out.
        for (int i = 0; i < W; i++) begin
            want[i]   = 0;
            budget[i] = 0;
        end
        for (int n = 0; n < 1500; n++) begin
            r = 4'b0000;
            for (int i = 0; i < W; i++) begin
                if (owner == i && want[i] != 0) begin
                    budget[i]--;
                    if (budget[i] <= 0) want[i] = 0;
                end else if (want[i] == 0 && $urandom_range(0, 2) == 0) begin
                    want[i]   = 1;
                    budget[i] = int'($urandom_range(1, 12));
                end
                if (want[i] != 0) r = r | (4'b0001 << i);
            end
            step(r);
        end
        step(4'b0000);
        step(4'b0000);

        // Reset mid-grant, then the pointer must be back at MSB.
        step(4'b0100);
        step(4'b0100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("reset_mid_grant");
        model_reset();
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step(4'b0110);
        step(4'b0110);
        step(4'b0000);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
